// File: rtl/t03_player_sprite_loader.sv
// -----------------------------------------------------------------------------
// t03_player_sprite_loader
//
// Writer side of the player sprite bus. A raster-ordered pixel stream arrives
// over a valid/ready handshake and is assembled into a back buffer. The back
// buffer is copied to the flat `player` bus in one cycle during vertical
// blanking, so the display never sees a half-written sprite.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-low reset
//   frame_start  one-cycle pulse; begin or restart a sprite load
//   pix_data     pixel value (RRRGGGBB; 0x00 is stored verbatim)
//   pix_valid    pix_data valid
//   pix_ready    loader accepts a pixel this cycle (registered, high in LOAD)
//   vblank       vertical blanking; the buffer swap is permitted
//   player       committed sprite bus to the display
//   busy         loader is not idle
//   load_done    one-cycle pulse in the cycle the new sprite becomes visible
//   stray_err    sticky; a pixel was offered while not loading
// -----------------------------------------------------------------------------
module t03_player_sprite_loader #(
    parameter int X_LENGTH = 15,
    parameter int Y_LENGTH = 20,
    parameter int PIX_W    = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                frame_start,
    input  logic [PIX_W-1:0]                    pix_data,
    input  logic                                pix_valid,
    output logic                                pix_ready,
    input  logic                                vblank,
    output logic [X_LENGTH*Y_LENGTH*PIX_W-1:0]  player,
    output logic                                busy,
    output logic                                load_done,
    output logic                                stray_err
);

    localparam int         N        = X_LENGTH * Y_LENGTH;
    localparam int         PLAYER_W = N * PIX_W;
    localparam logic [8:0] LAST_PTR = 9'(N - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_SWAP = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [8:0]            wr_ptr_r;
    logic [8:0]            wr_ptr_s;
    logic [8:0]            slot_s;
    logic [PLAYER_W-1:0]   back_r;
    logic [PLAYER_W-1:0]   player_r;
    logic                  pix_ready_r;
    logic                  busy_r;
    logic                  load_done_r;
    logic                  stray_err_r;
    logic                  xfer_s;
    logic                  wr_en_s;
    logic                  swap_s;
    logic                  stray_s;

    // pix_ready_r is high exactly when state_r is LOAD, so it qualifies transfers.
    assign xfer_s = pix_valid & pix_ready_r;

    // State and write-pointer register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= IDLE;
            wr_ptr_r <= 9'd0;
        end else begin
            state_r  <= state_s;
            wr_ptr_r <= wr_ptr_s;
        end
    end

    // Next-state and next-pointer logic.
    always_comb begin
        state_s  = state_r;
        wr_ptr_s = wr_ptr_r;
        case (state_r)
            IDLE: begin
                if (frame_start) begin
                    state_s  = LOAD;
                    wr_ptr_s = 9'd0;
                end else begin
                    state_s  = IDLE;
                end
            end
            LOAD: begin
                // A restart wins over a coincident transfer; that pixel is dropped.
                if (frame_start) begin
                    wr_ptr_s = 9'd0;
                end else if (xfer_s) begin
                    if (wr_ptr_r == LAST_PTR) begin
                        state_s  = WAIT_SWAP;
                        wr_ptr_s = 9'd0;
                    end else begin
                        wr_ptr_s = wr_ptr_r + 9'd1;
                    end
                end else begin
                    wr_ptr_s = wr_ptr_r;
                end
            end
            WAIT_SWAP: begin
                if (vblank) begin
                    state_s  = frame_start ? LOAD : IDLE;
                    wr_ptr_s = 9'd0;
                end else if (frame_start) begin
                    state_s  = LOAD;
                    wr_ptr_s = 9'd0;
                end else begin
                    state_s  = WAIT_SWAP;
                end
            end
            default: begin
                state_s  = IDLE;
                wr_ptr_s = 9'd0;
            end
        endcase
    end

    // Datapath controls: buffer write, swap request, stray detection, slot index.
    always_comb begin
        wr_en_s = 1'b0;
        swap_s  = 1'b0;
        stray_s = 1'b0;
        // First pixel lands in the top slot to match descending display indexing.
        slot_s  = LAST_PTR - wr_ptr_r;
        case (state_r)
            IDLE: begin
                stray_s = pix_valid;
            end
            LOAD: begin
                wr_en_s = xfer_s & ~frame_start;
            end
            WAIT_SWAP: begin
                swap_s  = vblank;
                stray_s = pix_valid;
            end
            default: begin
                stray_s = 1'b0;
            end
        endcase
    end

    // Back buffer: one slot written per accepted pixel; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            back_r <= {PLAYER_W{1'b0}};
        end else if (wr_en_s) begin
            back_r[int'(slot_s) * PIX_W +: PIX_W] <= pix_data;
        end else begin
            back_r <= back_r;
        end
    end

    // Committed sprite bus: whole-buffer copy on the swap cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            player_r <= {PLAYER_W{1'b0}};
        end else if (swap_s) begin
            player_r <= back_r;
        end else begin
            player_r <= player_r;
        end
    end

    // Registered status outputs derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pix_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            load_done_r <= 1'b0;
        end else begin
            pix_ready_r <= (state_s == LOAD);
            busy_r      <= (state_s != IDLE);
            load_done_r <= swap_s;
        end
    end

    // Sticky stray-pixel flag; a new frame_start clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stray_err_r <= 1'b0;
        end else if (frame_start) begin
            stray_err_r <= 1'b0;
        end else if (stray_s) begin
            stray_err_r <= 1'b1;
        end else begin
            stray_err_r <= stray_err_r;
        end
    end

    assign pix_ready = pix_ready_r;
    assign busy      = busy_r;
    assign load_done = load_done_r;
    assign stray_err = stray_err_r;
    assign player    = player_r;

endmodule

// File: tb/tb_t03_player_sprite_loader.sv
module tb_t03_player_sprite_loader;

    localparam int N  = 300;
    localparam int PW = 2400;

    logic          clk;
    logic          rst;
    logic          frame_start;
    logic [7:0]    pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          vblank;
    logic [PW-1:0] player;
    logic          busy;
    logic          load_done;
    logic          stray_err;

    int total = 0;
    int bad   = 0;

    // Reference model: pixels collected so far, what the display shows, flags.
    logic [7:0] m_back  [N];
    logic [7:0] m_shown [N];
    bit         m_acc;      // accepting pixels
    bit         m_pend;     // full sprite waiting for vblank
    int         m_cnt;      // pixels accepted in the current load
    bit         m_stray;
    bit         m_done;

    t03_player_sprite_loader dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .vblank      (vblank),
        .player      (player),
        .busy        (busy),
        .load_done   (load_done),
        .stray_err   (stray_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_update(input logic r, input logic fs, input logic pv,
                                input logic vb, input logic [7:0] pd);
        if (!r) begin
            for (int i = 0; i < N; i++) begin
                m_back[i]  = 8'h00;
                m_shown[i] = 8'h00;
            end
            m_acc = 0; m_pend = 0; m_cnt = 0; m_stray = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (fs)
                m_stray = 0;
            else if (pv && !m_acc)
                m_stray = 1;
            if (m_acc) begin
                if (fs) begin
                    m_cnt = 0;
                end else if (pv) begin
                    m_back[N-1-m_cnt] = pd;
                    m_cnt = m_cnt + 1;
                    if (m_cnt == N) begin
                        m_acc  = 0;
                        m_pend = 1;
                    end
                end
            end else if (m_pend) begin
                if (vb) begin
                    for (int i = 0; i < N; i++) m_shown[i] = m_back[i];
                    m_done = 1;
                    m_pend = 0;
                    if (fs) begin
                        m_acc = 1;
                        m_cnt = 0;
                    end
                end else if (fs) begin
                    m_pend = 0;
                    m_acc  = 1;
                    m_cnt  = 0;
                end
            end else if (fs) begin
                m_acc = 1;
                m_cnt = 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [PW-1:0] exp_player;
        int            slot;
        for (int i = 0; i < N; i++) exp_player[i*8 +: 8] = m_shown[i];
        total++;
        assert (pix_ready === m_acc) else begin
            bad++;
            $error("FAIL pix_ready: got %b exp %b", pix_ready, m_acc);
        end
        total++;
        assert (busy === (m_acc | m_pend)) else begin
            bad++;
            $error("FAIL busy: got %b exp %b", busy, m_acc | m_pend);
        end
        total++;
        assert (load_done === m_done) else begin
            bad++;
            $error("FAIL load_done: got %b exp %b", load_done, m_done);
        end
        total++;
        assert (stray_err === m_stray) else begin
            bad++;
            $error("FAIL stray_err: got %b exp %b", stray_err, m_stray);
        end
        total++;
        assert (player === exp_player) else begin
            bad++;
            slot = -1;
            for (int i = N - 1; i >= 0; i--)
                if (slot < 0 && player[i*8 +: 8] !== exp_player[i*8 +: 8]) slot = i;
            if (slot < 0) slot = 0;
            $error("FAIL player: slot %0d got %h exp %h", slot,
                   player[slot*8 +: 8], exp_player[slot*8 +: 8]);
        end
    endtask

    // One clock: drive inputs, advance, update model, check after the edge.
    task automatic step(input logic r, input logic fs, input logic pv,
                        input logic vb, input logic [7:0] pd);
        rst = r; frame_start = fs; pix_valid = pv; vblank = vb; pix_data = pd;
        @(posedge clk);
        model_update(r, fs, pv, vb, pd);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [7:0] v;
        rst = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; vblank = 1'b0; pix_data = 8'h00;
        #1;

        // Reset state.
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF);
        idle(2);

        // Full back-to-back load with (k+1) mod 256, then swap.
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < N; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'((k + 1) % 256));
        idle(3);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        total++;
        assert (player[2399:2392] === 8'h01) else begin
            bad++; $error("FAIL first_px: got %h exp 01", player[2399:2392]);
        end
        total++;
        assert (player[7:0] === 8'h2C) else begin
            bad++; $error("FAIL last_px: got %h exp 2c", player[7:0]);
        end
        total++;
        assert (load_done === 1'b1) else begin
            bad++; $error("FAIL done_pulse: got %b exp 1", load_done);
        end
        idle(2);
        total++;
        assert (busy === 1'b0 && load_done === 1'b0) else begin
            bad++; $error("FAIL after_swap: busy %b done %b exp 0 0", busy, load_done);
        end

        // Toggling valid with random early vblank; no swap until sprite is full.
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2 * N; i++)
            step(1'b1, 1'b0, (i % 2 == 0), 1'($urandom_range(0, 1)), 8'($urandom));
        idle(2);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        idle(1);

        // Partial load of 0xAA, restart, full load of 0x55.
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'hAA);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'hAA);
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < N; i++) begin
            total++;
            assert (player[i*8 +: 8] === 8'h55) else begin
                bad++; $error("FAIL all55: slot %0d got %h exp 55", i, player[i*8 +: 8]);
            end
        end

        // Stray pixel while idle, cleared by frame_start.
        idle(1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h33);
        total++;
        assert (stray_err === 1'b1) else begin
            bad++; $error("FAIL stray_set: got %b exp 1", stray_err);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

        // Random full load, stray in WAIT_SWAP, then vblank + frame_start together.
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h77);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        total++;
        assert (pix_ready === 1'b1 && load_done === 1'b1) else begin
            bad++; $error("FAIL swap_restart: ready %b done %b exp 1 1", pix_ready, load_done);
        end

        // Reset at pixel 150, then a full normal load.
        for (int i = 0; i < 150; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'($urandom));
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h12);
        total++;
        assert (player === {PW{1'b0}} && pix_ready === 1'b0 && busy === 1'b0) else begin
            bad++; $error("FAIL mid_reset: ready %b busy %b exp 0 0", pix_ready, busy);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < N; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        idle(1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            v = 8'($urandom);
            step(($urandom_range(0, 999) != 0), ($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/t03_player_sprite_loader.md
Name: t03_player_sprite_loader

Overview:
- Writer side of the player sprite bus: takes a raster-ordered stream of 8-bit pixels over a valid/ready handshake and assembles them into a back buffer.
- Commits the back buffer to the flat `player` bus during vertical blanking, so the display path never sees a half-written sprite.
- Sits between the sprite source (ROM walker / SPI fetch) and the player display blocks.

Parameters:
- X_LENGTH, 15, sprite width in pixels
- Y_LENGTH, 20, sprite height in pixels
- PIX_W, 8, bits per pixel (RRRGGGBB colour; 0x00 = use display default colour)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- frame_start  input  1  one-cycle pulse; begin/restart a sprite load
- pix_data  input  PIX_W  pixel value
- pix_valid  input  1  pix_data valid
- pix_ready  output  1  loader accepts a pixel this cycle
- vblank  input  1  high during vertical blanking; swap permitted
- player  output  X_LENGTH*Y_LENGTH*PIX_W (2400)  committed sprite bus to display
- busy  output  1  state != IDLE
- load_done  output  1  one-cycle pulse, cycle after commit
- stray_err  output  1  sticky; pixel offered while not loading

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst), sampled on posedge clk.
- Reset values:
  - state = IDLE; wr_ptr = 0; back buffer = 0.
  - player = 0; pix_ready = 0; load_done = 0; stray_err = 0; busy = 0.
- Storage: back buffer of N = X_LENGTH*Y_LENGTH = 300 entries × PIX_W. wr_ptr is 9 bits, range 0..N-1.
- Mapping: the k-th accepted pixel (0-based, raster order, row-major from the top-left) goes to slot (N-1-k), i.e. bits [(N-1-k)*PIX_W +: PIX_W].
  - k=0 lands in player[2399:2392].
  - k=299 lands in player[7:0].
  - This matches the display's descending displacement indexing.
- FSM states: IDLE, LOAD, WAIT_SWAP. pix_ready is a registered output, high only in LOAD.
- IDLE:
  - frame_start → LOAD, wr_ptr ← 0.
  - pix_valid → stray_err ← 1; pixel dropped.
- LOAD:
  - A transfer occurs on a cycle with pix_valid & pix_ready. On a transfer: write slot, wr_ptr++.
  - On the transfer with wr_ptr == N-1: → WAIT_SWAP, and pix_ready is low from the next cycle.
  - frame_start in LOAD (with or without a coincident transfer) → restart: wr_ptr ← 0, stay in LOAD, coincident pixel discarded.
  - player is unchanged throughout LOAD.
- WAIT_SWAP:
  - vblank high → player ← back buffer (all 2400 bits, single cycle, visible the next cycle); load_done pulses the following cycle.
  - After the swap, go to IDLE; if frame_start is also high in that cycle, go to LOAD with wr_ptr ← 0 instead.
  - frame_start without vblank → discard back buffer contents, → LOAD with wr_ptr ← 0; no swap.
  - pix_valid in WAIT_SWAP → stray_err ← 1.
- stray_err is cleared only by frame_start or reset.
- Back buffer is not cleared between loads; only reset clears it.
- Reset mid-operation: all state returns to reset values in the next cycle; player goes to 0.
- Pixel value 0x00 is stored verbatim; substitution to the default colour is the display's job, not the loader's.

Test Plan:
- Reset, frame_start, then 300 pixels with value (k+1) mod 256 back-to-back, then vblank → player[2399:2392]=0x01, player[7:0]=0x2C, load_done=1 exactly one cycle after the swap, busy=0 afterwards.
- Same load with pix_valid toggling every other cycle, and vblank asserted before the load completes → no early swap; pix_ready drops after the 300th transfer; swap occurs on the first vblank in WAIT_SWAP.
- Load 100 pixels of 0xAA, pulse frame_start, load 300 pixels of 0x55, vblank → every slot = 0x55; the prior player contents are held unchanged until the swap cycle.
- pix_valid with 0x33 while IDLE → stray_err=1, player unchanged; next frame_start → stray_err=0.
- In WAIT_SWAP, vblank and frame_start asserted in the same cycle → player updated, state=LOAD, wr_ptr=0, pix_ready=1 the next cycle.
- rst low during LOAD at pixel 150 → next cycle: player=0, pix_ready=0, busy=0; a subsequent full load works normally.
